// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - debounced seven-segment digit reader with sequence checking
// Samples an asynchronous segment bus, accepts stable patterns and tracks a 0..9 seconds sequence.
module seven_segment_reader #(
  parameter int STABLE_CYCLES = 16,
  parameter bit SEG_INVERT    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic        clr,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        new_digit,
  output logic        pattern_err,
  output logic        seq_err,
  output logic [15:0] seconds_count,
  output logic [7:0]  err_count
);

  localparam logic [6:0] INV_MASK = SEG_INVERT ? 7'h7F : 7'h00;
  localparam logic [7:0] STABLE   = 8'(STABLE_CYCLES);

  typedef enum logic {WAIT_FIRST, LOCKED} state_t;

  logic [6:0] s1, s2, cand, acc_pat;
  logic [7:0] stab_cnt;
  logic       acc_q;

  state_t      state, state_n;
  logic [3:0]  digit_n;
  logic        valid_n, new_digit_n, pattern_err_n, seq_err_n, err_inc;
  logic [15:0] seconds_n;
  logic [7:0]  err_n;
  logic        dec_ok;
  logic [3:0]  dec_d;
  logic [3:0]  digit_next;

  // Input synchronizer and stability tracker; acc_q marks the accept edge for the output stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1       <= 7'h00;
      s2       <= 7'h00;
      cand     <= 7'h00;
      acc_pat  <= 7'h00;
      stab_cnt <= 8'd0;
      acc_q    <= 1'b0;
    end else begin
      s1    <= seg_in ^ INV_MASK;
      s2    <= s1;
      acc_q <= 1'b0;
      if (s2 != cand) begin
        cand     <= s2;
        stab_cnt <= 8'd0;
      end else if (stab_cnt < STABLE) begin
        stab_cnt <= stab_cnt + 8'd1;
        if (stab_cnt == STABLE - 8'd1 && cand != acc_pat) begin
          acc_pat <= cand;
          acc_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    dec_ok = 1'b1;
    dec_d  = 4'd0;
    case (acc_pat)
      7'h3F: dec_d = 4'd0;
      7'h06: dec_d = 4'd1;
      7'h5B: dec_d = 4'd2;
      7'h4F: dec_d = 4'd3;
      7'h66: dec_d = 4'd4;
      7'h6D: dec_d = 4'd5;
      7'h7D: dec_d = 4'd6;
      7'h07: dec_d = 4'd7;
      7'h7F: dec_d = 4'd8;
      7'h6F: dec_d = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  assign digit_next = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  always_comb begin
    state_n       = state;
    digit_n       = digit;
    valid_n       = digit_valid;
    new_digit_n   = 1'b0;
    pattern_err_n = 1'b0;
    seq_err_n     = 1'b0;
    seconds_n     = seconds_count;
    err_n         = err_count;
    err_inc       = 1'b0;
    if (acc_q) begin
      if (!dec_ok) begin
        pattern_err_n = 1'b1;
        valid_n       = 1'b0;
        err_inc       = 1'b1;
        state_n       = WAIT_FIRST;
      end else begin
        digit_n     = dec_d;
        new_digit_n = 1'b1;
        case (state)
          WAIT_FIRST: begin
            valid_n = 1'b1;
            state_n = LOCKED;
          end
          LOCKED: begin
            if (dec_d == digit_next) begin
              seconds_n = seconds_count + 16'd1;
            end else begin
              seq_err_n = 1'b1;
              err_inc   = 1'b1;
            end
          end
          default: state_n = WAIT_FIRST;
        endcase
      end
    end
    if (err_inc && err_count != 8'hFF) begin
      err_n = err_count + 8'd1;
    end
    // Clear wins over any increment on the same edge.
    if (clr) begin
      seconds_n = 16'd0;
      err_n     = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= WAIT_FIRST;
      digit         <= 4'd0;
      digit_valid   <= 1'b0;
      new_digit     <= 1'b0;
      pattern_err   <= 1'b0;
      seq_err       <= 1'b0;
      seconds_count <= 16'd0;
      err_count     <= 8'd0;
    end else begin
      state         <= state_n;
      digit         <= digit_n;
      digit_valid   <= valid_n;
      new_digit     <= new_digit_n;
      pattern_err   <= pattern_err_n;
      seq_err       <= seq_err_n;
      seconds_count <= seconds_n;
      err_count     <= err_n;
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb/tb_seven_segment_reader.sv - self-checking bench for seven_segment_reader
// A run-length model of the sampled input drives a behavioural digit/counter model.
module tb_seven_segment_reader;

  localparam int S = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, clr = 1'b0;
  logic [6:0]  seg = 7'h00;
  logic [3:0]  digit;
  logic        digit_valid, new_digit, pattern_err, seq_err;
  logic [15:0] seconds_count;
  logic [7:0]  err_count;

  logic        reset1 = 1'b0, clr1 = 1'b0;
  logic [6:0]  seg1 = 7'h00;
  logic [3:0]  digit1;
  logic        digit_valid1, new_digit1, pattern_err1, seq_err1;
  logic [15:0] seconds_count1;
  logic [7:0]  err_count1;

  seven_segment_reader #(.STABLE_CYCLES(S), .SEG_INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .seg_in(seg), .clr(clr),
    .digit(digit), .digit_valid(digit_valid), .new_digit(new_digit),
    .pattern_err(pattern_err), .seq_err(seq_err),
    .seconds_count(seconds_count), .err_count(err_count)
  );

  seven_segment_reader #(.STABLE_CYCLES(2), .SEG_INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset1), .seg_in(seg1), .clr(clr1),
    .digit(digit1), .digit_valid(digit_valid1), .new_digit(new_digit1),
    .pattern_err(pattern_err1), .seq_err(seq_err1),
    .seconds_count(seconds_count1), .err_count(err_count1)
  );

  int checks = 0, errors = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  // Model: an accept is the sample where a run of identical inputs reaches S+1 and differs
  // from the last accepted pattern; its effect shows on the outputs three edges later.
  bit         m_init = 1'b0;
  logic [6:0] m_last, m_acc;
  int         m_run;
  bit         pv [3];
  logic [6:0] pp [3];
  int         m_digit, m_sec, m_err, md;
  bit         m_valid, m_nd, m_pe, m_se, m_locked, det;

  always @(posedge clk) begin
    if (!reset) begin
      m_init = 1'b1; m_last = 7'h00; m_run = 3; m_acc = 7'h00;
      for (int i = 0; i < 3; i++) pv[i] = 1'b0;
      m_digit = 0; m_valid = 0; m_nd = 0; m_pe = 0; m_se = 0;
      m_locked = 0; m_sec = 0; m_err = 0;
    end else begin
      m_nd = 0; m_pe = 0; m_se = 0;
      if (pv[2]) begin
        md = lookup(pp[2]);
        if (md < 0) begin
          m_pe = 1; m_valid = 0; m_locked = 0;
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end else if (!m_locked) begin
          m_digit = md; m_valid = 1; m_nd = 1; m_locked = 1;
        end else if (md == (m_digit + 1) % 10) begin
          m_digit = md; m_nd = 1; m_sec = (m_sec + 1) % 65536;
        end else begin
          m_digit = md; m_nd = 1; m_se = 1;
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end
      end
      if (clr) begin m_sec = 0; m_err = 0; end
      if (seg == m_last) begin
        if (m_run < 100000) m_run++;
      end else begin
        m_last = seg; m_run = 1;
      end
      det = (m_run == S + 1) && (m_last != m_acc);
      if (det) m_acc = m_last;
      pv[2] = pv[1]; pp[2] = pp[1];
      pv[1] = pv[0]; pp[1] = pp[0];
      pv[0] = det;   pp[0] = m_last;
    end
  end

  int n_nd = 0, n_pe = 0, n_se = 0;

  always @(negedge clk) begin
    if (m_init) begin
      check("digit", digit, m_digit);
      check("digit_valid", digit_valid, m_valid);
      check("new_digit", new_digit, m_nd);
      check("pattern_err", pattern_err, m_pe);
      check("seq_err", seq_err, m_se);
      check("seconds_count", seconds_count, m_sec);
      check("err_count", err_count, m_err);
      n_nd += int'(new_digit);
      n_pe += int'(pattern_err);
      n_se += int'(seq_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int lat, b_nd, b_pe, b_se, cur, r;

  initial begin
    tick(3);
    check("rst_digit", digit, 0);
    check("rst_valid", digit_valid, 0);
    check("rst_pulses", {new_digit, pattern_err, seq_err}, 0);
    check("rst_counts", {seconds_count, err_count}, 0);

    // Reset release with 0 applied: first sampling edge is edge 0, pulse follows edge S+3.
    reset = 1'b1; seg = 7'h3F; lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (new_digit) begin lat = i; break; end
    end
    check("first_latency", lat, S + 4);
    check("first_digit", digit, 0);
    check("first_valid", digit_valid, 1);
    check("first_seconds", seconds_count, 0);
    #1;

    reset = 1'b0; tick(1); reset = 1'b1;
    b_nd = n_nd; b_se = n_se;
    for (int i = 0; i <= 10; i++) begin seg = pats[i % 10]; tick(40); end
    check("seq_new_digits", n_nd - b_nd, 11);
    check("seq_seconds", seconds_count, 10);
    check("seq_seq_errs", n_se - b_se, 0);
    check("seq_err_count", err_count, 0);

    seg = 7'h06; tick(40); seg = 7'h5B; tick(40);
    b_nd = n_nd; b_pe = n_pe;
    seg = 7'h7F; tick(1); seg = 7'h5B; tick(40);
    check("glitch_pulses", (n_nd - b_nd) + (n_pe - b_pe), 0);
    check("glitch_digit", digit, 2);

    seg = 7'h4F; tick(40);
    b_se = n_se; b_pe = n_pe;
    seg = 7'h7D; tick(40);
    check("jump_seq_err", n_se - b_se, 1);
    check("jump_digit", digit, 6);
    check("jump_err_count", err_count, 1);
    seg = 7'h49; tick(40);
    check("bad_pattern_err", n_pe - b_pe, 1);
    check("bad_valid", digit_valid, 0);
    check("bad_err_count", err_count, 2);

    for (int i = 0; i < 260; i++) begin seg = (i % 2 == 0) ? 7'h00 : 7'h49; tick(20); end
    tick(5);
    check("sat_err_count", err_count, 255);

    seg = 7'h3F; tick(S + 3); clr = 1'b1; tick(1); clr = 1'b0;
    check("clr_new_digit", new_digit, 1);
    check("clr_digit", digit, 0);
    check("clr_seconds", seconds_count, 0);
    check("clr_err_count", err_count, 0);

    cur = 0;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin cur = (cur + 1) % 10; seg = pats[cur]; end
      else if (r < 75) begin cur = $urandom_range(0, 9); seg = pats[cur]; end
      else if (r < 90) seg = 7'($urandom_range(0, 127));
      else seg = 7'h00;
      r = $urandom_range(0, 99);
      if (r < 5) begin clr = 1'b1; tick(1); clr = 1'b0; end
      else if (r < 8) begin reset = 1'b0; tick(1); reset = 1'b1; end
      tick($urandom_range(1, 45));
    end

    // Inverted-input instance with the minimum stability window.
    tick(1); reset1 = 1'b1; seg1 = 7'h40; tick(10);
    check("inv_digit", digit1, 0);
    check("inv_valid", digit_valid1, 1);
    seg1 = 7'h79; tick(2);
    reset1 = 1'b0; tick(1); reset1 = 1'b1;
    check("inv_rst_digit", digit1, 0);
    check("inv_rst_flags", {digit_valid1, new_digit1, pattern_err1, seq_err1}, 0);
    check("inv_rst_counts", {seconds_count1, err_count1}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, meaning: consecutive identical synchronized samples required to accept a pattern; legal range 2..255.
REQ-002 Parameter SEG_INVERT, default 0, meaning: 1 = segment inputs are active-low and are inverted before decode.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-low reset; sampled on the clk rising edge; no asynchronous reset path exists.
REQ-005 seg_in  input  7  segment levels {g,f,e,d,c,b,a}, bit0 = a; asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of seconds_count and err_count.
REQ-007 digit  output  4  last accepted decimal digit 0..9.
REQ-008 digit_valid  output  1  high while digit reflects a valid accepted pattern.
REQ-009 new_digit  output  1  one-cycle pulse on each valid accept.
REQ-010 pattern_err  output  1  one-cycle pulse on each invalid accept.
REQ-011 seq_err  output  1  one-cycle pulse on each valid accept that is not previous digit +1 mod 10.
REQ-012 seconds_count  output  16  count of in-sequence accepts.
REQ-013 err_count  output  8  count of pattern_err plus seq_err events, saturating.

Function
REQ-014 Input path: seg_in (XOR SEG_INVERT) passes through a 2-flop synchronizer; s2 is the second-stage output.
REQ-015 Stability tracking: cand register and stab_cnt (8 bit); if s2 != cand: cand <= s2, stab_cnt <= 0; else if stab_cnt < STABLE_CYCLES: stab_cnt <= stab_cnt + 1.
REQ-016 Accept event: occurs on the edge where stab_cnt becomes STABLE_CYCLES AND cand != last accepted pattern (acc_pat); acc_pat <= cand on accept.
REQ-017 Latency: seg_in changed and held from edge k -> accept outputs visible after edge k+STABLE_CYCLES+3.
REQ-018 A glitch shorter than STABLE_CYCLES+1 synchronized cycles produces no accept, and acc_pat is unchanged.
REQ-019 Decode table (hex): 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9; every other value, including 00 (blank), is invalid.
REQ-020 FSM states: WAIT_FIRST (no valid reference digit) and LOCKED.
REQ-021 Valid accept in WAIT_FIRST: digit <= d, digit_valid <= 1, new_digit pulse, no count change, -> LOCKED.
REQ-022 Valid accept in LOCKED with d == (digit+1) mod 10 (9 -> 0 included): digit <= d, new_digit pulse, seconds_count +1 (wraps FFFF -> 0000).
REQ-023 Valid accept in LOCKED otherwise: digit <= d, new_digit and seq_err pulse, err_count +1, remain LOCKED.
REQ-024 Invalid accept (any state): pattern_err pulse, digit_valid <= 0, digit holds, err_count +1, -> WAIT_FIRST.
REQ-025 err_count saturates at FF; further events leave it at FF.
REQ-026 clr and accept on the same edge: both counters go to 0 and do not increment; digit, digit_valid, pulses and FSM still update per the accept.
REQ-027 Pulse outputs are registered and high for exactly one cycle per event; at most one accept occurs per cycle.

Reset
REQ-028 With reset low at a clk edge: synchronizer flops, cand and acc_pat <= 00; stab_cnt <= 0; FSM <= WAIT_FIRST; digit <= 0; digit_valid, new_digit, pattern_err and seq_err <= 0; seconds_count <= 0; err_count <= 0.
REQ-029 Reset asserted mid-stability-count or mid-pulse: the pulse is terminated and the pending accept is discarded.
REQ-030 After reset, blank input (00) produces no accept, because acc_pat = 00.

Verification
REQ-031 Reset release, seg_in=3F held -> new_digit pulse after edge STABLE_CYCLES+3 (19 edges at default), digit=0, digit_valid=1, seconds_count=0.
REQ-032 Sequence 3F,06,...,6F,3F, each held 40 cycles -> 11 new_digit pulses, seconds_count=10, seq_err never high, err_count=0.
REQ-033 Digit 2 stable, then 1-cycle glitch to 7F, then back to 5B -> no pulses; digit stays 2.
REQ-034 LOCKED at 3, then 7D (6) applied -> seq_err and new_digit pulse, digit=6, err_count=1; then 49 applied -> pattern_err, digit_valid=0, err_count=2, FSM WAIT_FIRST.
REQ-035 Drive 260 alternating invalid patterns (49/00) -> err_count saturates at FF; clr asserted on the same edge as an accept -> counters 0, digit updated.
REQ-036 SEG_INVERT=1, seg_in=~3F&7F (40) -> digit=0 accepted; reset pulsed low for 1 cycle mid-count -> all outputs at REQ-028 values the next cycle.
